// File: rtl/drv_segment_pkg.sv
// Shared types, the seven-segment glyph table and its lookup helper
// for the multiplexed segment display driver.
package drv_segment_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Active-high segment codes, entry 0 in the least significant slot
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t glyph_lookup(input nibble_t value, input logic hex);
    if (!hex && value > 4'd9) return SEG_BLANK;
    return GLYPH_TBL[value];
  endfunction

endpackage

// File: rtl/drv_segment_glyph.sv
// Combinational digit-to-segment encoder with forced blanking.
module drv_segment_glyph
  import drv_segment_pkg::*;
(
  input  nibble_t value,
  input  logic    hex,
  input  logic    blank,
  output seg_t    seg
);

  assign seg = blank ? SEG_BLANK : glyph_lookup(value, hex);

endmodule

// File: rtl/drv_segment_scan.sv
// Multiplexed seven-segment scanner: prescaled digit scan, frame-aligned
// value update, leading-zero blanking and PWM brightness per digit slot.
module drv_segment_scan
  import drv_segment_pkg::*;
#(
  parameter int p_count         = 4,
  parameter int p_div           = 1000,
  parameter int p_bright_w      = 4,
  parameter int p_sgmnt_act_low = 0,
  parameter int p_digit_act_low = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [3:0]            i_value [p_count],
  input  logic                  i_load,
  input  logic                  i_hex,
  input  logic                  i_blank_lz,
  input  logic [p_bright_w-1:0] i_bright,
  output logic [6:0]            o_drv_sgmnt,
  output logic [p_count-1:0]    o_drv_digit,
  output logic                  o_frame
);

  localparam int PC_W = $clog2(p_div);
  localparam int DI_W = (p_count > 1) ? $clog2(p_count) : 1;
  localparam int TH_W = $clog2(p_div + 1);
  localparam int PR_W = p_bright_w + 33;

  localparam logic [PC_W-1:0]    PRE_LAST = PC_W'(p_div - 1);
  localparam logic [DI_W-1:0]    DIG_LAST = DI_W'(p_count - 1);
  localparam seg_t               SEG_OFF  = (p_sgmnt_act_low != 0) ? 7'h7F : 7'h00;
  localparam logic [p_count-1:0] DIG_OFF  = (p_digit_act_low != 0) ? '1 : '0;

  logic [PC_W-1:0] pre_cnt, pre_nxt;
  logic [DI_W-1:0] dig_idx, dig_nxt;
  logic            pre_wrap, frame_wrap;
  nibble_t         pend_val [p_count];
  nibble_t         shad_val [p_count];
  logic            pend_hex, shad_hex;
  logic [PR_W-1:0] prod;
  logic [TH_W-1:0] thr_q, thr_now, thr_eff;
  logic            active, blank;
  seg_t            glyph;

  always_comb begin
    pre_wrap   = (pre_cnt == PRE_LAST);
    frame_wrap = pre_wrap && (dig_idx == DIG_LAST);
    pre_nxt    = pre_wrap ? '0 : pre_cnt + PC_W'(1);
    dig_nxt    = dig_idx;
    if (pre_wrap) dig_nxt = (dig_idx == DIG_LAST) ? '0 : dig_idx + DI_W'(1);
  end

  // Threshold is taken live on the first slot cycle so that cycle already uses it
  always_comb begin
    prod    = (PR_W'(i_bright) + PR_W'(1)) * PR_W'(p_div);
    thr_now = TH_W'(prod >> p_bright_w);
    thr_eff = (pre_cnt == '0) ? thr_now : thr_q;
    active  = TH_W'(pre_cnt) < thr_eff;
  end

  always_comb begin
    blank = 1'b0;
    if (i_blank_lz && dig_idx != '0) begin
      blank = 1'b1;
      for (int j = 0; j < p_count; j++)
        if (j >= int'(dig_idx) && shad_val[j] != 4'd0) blank = 1'b0;
    end
  end

  drv_segment_glyph u_glyph (
    .value (shad_val[dig_idx]),
    .hex   (shad_hex),
    .blank (blank),
    .seg   (glyph)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pre_cnt     <= '0;
      dig_idx     <= '0;
      thr_q       <= '0;
      pend_hex    <= 1'b0;
      shad_hex    <= 1'b0;
      o_frame     <= 1'b0;
      o_drv_sgmnt <= SEG_OFF;
      o_drv_digit <= DIG_OFF;
      for (int j = 0; j < p_count; j++) begin
        pend_val[j] <= '0;
        shad_val[j] <= '0;
      end
    end else begin
      pre_cnt <= pre_nxt;
      dig_idx <= dig_nxt;
      if (pre_cnt == '0) thr_q <= thr_now;
      o_frame <= (pre_nxt == PRE_LAST) && (dig_nxt == DIG_LAST);

      if (i_load) begin
        pend_hex <= i_hex;
        for (int j = 0; j < p_count; j++) pend_val[j] <= i_value[j];
      end
      // A load landing on the boundary bypasses pending so it shows this frame
      if (frame_wrap) begin
        shad_hex <= i_load ? i_hex : pend_hex;
        for (int j = 0; j < p_count; j++)
          shad_val[j] <= i_load ? i_value[j] : pend_val[j];
      end

      if (active) begin
        o_drv_digit <= DIG_OFF ^ (p_count'(1) << dig_idx);
        o_drv_sgmnt <= SEG_OFF ^ glyph;
      end else begin
        o_drv_digit <= DIG_OFF;
        o_drv_sgmnt <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_drv_segment_scan.sv
// Bench for drv_segment_scan (4 digits, 16 clocks/slot, active-low pins):
// glyph table vectors, timing corner sequences and a random run against a time-based model.
module tb_drv_segment_scan;

  localparam int N = 4;
  localparam int D = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   value [N];
  logic         load = 1'b0;
  logic         hex = 1'b0;
  logic         blz = 1'b0;
  logic [W-1:0] bright = '1;
  logic [6:0]   seg;
  logic [N-1:0] dig;
  logic         frame;

  int checks = 0;
  int errors = 0;

  drv_segment_scan #(
    .p_count(N), .p_div(D), .p_bright_w(W),
    .p_sgmnt_act_low(1), .p_digit_act_low(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load),
    .i_hex(hex), .i_blank_lz(blz), .i_bright(bright),
    .o_drv_sgmnt(seg), .o_drv_digit(dig), .o_frame(frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v, input logic h);
    if (!h && v > 4'd9) return 7'h00;
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Reference model: scan position derived from cycles elapsed since reset
  int           t;
  logic [3:0]   m_pend [N];
  logic [3:0]   m_shad [N];
  logic         m_pend_hex, m_shad_hex;
  int           m_thr;
  logic [6:0]   exp_seg = 7'h7F;
  logic [N-1:0] exp_dig = '1;
  logic         exp_frame = 1'b0;
  int           rst_epoch = 0;

  always @(posedge clk) begin : model_b
    int pre, didx;
    logic lz;
    logic [6:0] g;
    if (!rst_n) begin
      t = 0; m_thr = 0; m_pend_hex = 1'b0; m_shad_hex = 1'b0;
      for (int j = 0; j < N; j++) begin m_pend[j] = 4'd0; m_shad[j] = 4'd0; end
      exp_seg = 7'h7F; exp_dig = '1; exp_frame = 1'b0;
      rst_epoch++;
    end else begin
      pre  = t % D;
      didx = (t / D) % N;
      if (pre == 0) m_thr = ((int'(bright) + 1) * D) >> W;
      lz = blz && (didx > 0);
      for (int j = 0; j < N; j++) if (j >= didx && m_shad[j] != 4'd0) lz = 1'b0;
      g = lz ? 7'h00 : ref_glyph(m_shad[didx], m_shad_hex);
      if (pre < m_thr) begin
        exp_seg = ~g;
        exp_dig = ~(N'(1) << didx);
      end else begin
        exp_seg = 7'h7F;
        exp_dig = '1;
      end
      if (load) begin
        m_pend_hex = hex;
        for (int j = 0; j < N; j++) m_pend[j] = value[j];
      end
      if (pre == D - 1 && didx == N - 1) begin
        m_shad_hex = m_pend_hex;
        for (int j = 0; j < N; j++) m_shad[j] = m_pend[j];
      end
      t++;
      exp_frame = ((t % D) == D - 1) && (((t / D) % N) == N - 1);
    end
  end

  int cyc = 0;
  int last_frame_cyc = -1;
  int last_epoch = -1;

  always @(negedge clk) begin
    cyc++;
    checks++;
    if (seg !== exp_seg || dig !== exp_dig || frame !== exp_frame) begin
      errors++;
      $display("FAIL model cyc %0d: seg=%h want %h digit=%b want %b frame=%b want %b",
               cyc, seg, exp_seg, dig, exp_dig, frame, exp_frame);
    end
    checks++;
    if (!$onehot0(~dig)) begin
      errors++;
      $display("FAIL onehot cyc %0d: digit pins=%b, at most one low required", cyc, dig);
    end
    if (frame) begin
      if (last_epoch == rst_epoch && last_frame_cyc >= 0) begin
        checks++;
        if (cyc - last_frame_cyc != N * D) begin
          errors++;
          $display("FAIL frame_period: got %0d cycles, required %0d", cyc - last_frame_cyc, N * D);
        end
      end
      last_frame_cyc = cyc;
      last_epoch = rst_epoch;
    end
  end

  typedef struct packed {
    logic [15:0] vals;
    logic        hx;
    logic        lz;
    logic [27:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_vals(input logic [15:0] v);
    for (int k = 0; k < N; k++) value[k] = v[4*k +: 4];
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic h);
    set_vals(v);
    hex = h;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    for (int k = 0; k < 4 * N * D; k++) begin
      @(negedge clk);
      if (frame) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_frame timeout: o_frame=%b, pulse required", frame);
  endtask

  task automatic check_digit(input string name, input int k, input logic [6:0] g);
    logic [N-1:0] ed;
    logic [6:0]   es;
    ed = ~(N'(1) << k);
    es = ~g;
    checks++;
    if (dig !== ed || seg !== es) begin
      errors++;
      $display("FAIL %s digit %0d: seg=%h digit=%b, required seg=%h digit=%b", name, k, seg, dig, es, ed);
    end
  endtask

  task automatic check_off(input string name);
    checks++;
    if (seg !== 7'h7F || dig !== '1 || frame !== 1'b0) begin
      errors++;
      $display("FAIL %s: seg=%h digit=%b frame=%b, required 7f/1111/0", name, seg, dig, frame);
    end
  endtask

  task automatic sample_frame(input string name, input logic [27:0] ex);
    wait_frame();
    tick(2 + D / 2);
    for (int k = 0; k < N; k++) begin
      check_digit(name, k, ex[7*k +: 7]);
      if (k < N - 1) tick(D);
    end
  endtask

  initial begin
    int cnt;
    int bval [4];
    int bexp [4];

    tbl[0] = '{16'h0003, 1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h4F}};
    tbl[1] = '{16'h00B0, 1'b0, 1'b0, {7'h3F, 7'h3F, 7'h00, 7'h3F}};
    tbl[2] = '{16'h00B0, 1'b1, 1'b0, {7'h3F, 7'h3F, 7'h7C, 7'h3F}};
    tbl[3] = '{16'hFA21, 1'b1, 1'b0, {7'h71, 7'h77, 7'h5B, 7'h06}};
    tbl[4] = '{16'h0000, 1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    tbl[5] = '{16'h0705, 1'b0, 1'b1, {7'h00, 7'h07, 7'h3F, 7'h6D}};
    tbl[6] = '{16'h4698, 1'b0, 1'b0, {7'h66, 7'h7D, 7'h6F, 7'h7F}};
    tbl[7] = '{16'hBCDE, 1'b1, 1'b0, {7'h7C, 7'h39, 7'h5E, 7'h79}};
    tbl[8] = '{16'hBCDE, 1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00}};
    tbl[9] = '{16'h9000, 1'b0, 1'b1, {7'h6F, 7'h3F, 7'h3F, 7'h3F}};
    bval = '{3, 15, 0, 7};
    bexp = '{16, 64, 4, 32};

    set_vals(16'h0000);
    rst_n = 1'b0;
    tick(3);
    check_off("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      blz = tbl[i].lz;
      pulse_load(tbl[i].vals, tbl[i].hx);
      sample_frame($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Duty cycle: count active cycles over one whole frame
    blz = 1'b0;
    pulse_load(16'h8888, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bright = W'(bval[i]);
      wait_frame();
      wait_frame();
      cnt = 0;
      for (int c = 0; c < N * D; c++) begin
        tick(1);
        if (dig != '1) cnt++;
      end
      checks++;
      if (cnt != bexp[i]) begin
        errors++;
        $display("FAIL bright%0d: active cycles=%0d, required %0d", bval[i], cnt, bexp[i]);
      end
    end
    bright = '1;

    // Mid-frame load must not tear the current frame
    pulse_load(16'h1111, 1'b0);
    wait_frame();
    wait_frame();
    tick(2 + D + D / 2);
    set_vals(16'h2222);
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(2 * D - 1);
    check_digit("midload_old", 3, 7'h06);
    wait_frame();
    tick(2 + D / 2);
    check_digit("midload_new", 0, 7'h5B);

    // Load coincident with the frame pulse shows from digit 0 onward
    wait_frame();
    set_vals(16'h3333);
    load = 1'b1;
    tick(1);
    load = 1'b0;
    check_digit("coinc_prev", 3, 7'h5B);
    tick(1);
    check_digit("coinc_new", 0, 7'h4F);

    // Reset mid-scan, then restart from digit 0
    tick(D + 5);
    rst_n = 1'b0;
    tick(1);
    check_off("rst_mid");
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_digit("rst_restart", 0, 7'h3F);
    cnt = 0;
    for (int k = 0; k < 4 * N * D; k++) begin
      tick(1);
      cnt++;
      if (frame) break;
    end
    checks++;
    if (cnt != N * D - 2) begin
      errors++;
      $display("FAIL rst_first_frame: pulse after %0d cycles, required %0d", cnt, N * D - 2);
    end

    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_vals(16'($urandom));
        hex = 1'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 499) == 0) blz = 1'($urandom);
      if ($urandom_range(0, 299) == 0) bright = W'($urandom);
      rst_n = ($urandom_range(0, 4999) != 0);
      tick(1);
    end
    load = 1'b0;
    rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
